// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares the core's single data-memory port between the CPU and a host/debug
// port. The CPU passes straight through combinationally and always wins. A host
// request is buffered and issued in the first cycle where the CPU makes no data
// access.
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   cpu_daddr/ddout/doe/dwe0/dwe1     CPU data port in; cpu_ddin read data out
//   host_req/we/be/addr/wdata         host request (single-cycle req pulse)
//   host_busy/ack/rdata               host status, completion pulse, read data
//   mem_addr/wdata/oe/we0/we1         to the data memory; mem_rdata async read
//   starve_cnt, starve_flag           host wait-cycle count and sticky flag
module dmem_arbiter #(
  parameter logic [7:0] STARVE_LIMIT = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_daddr,
  input  logic [15:0] cpu_ddout,
  input  logic        cpu_doe,
  input  logic        cpu_dwe0,
  input  logic        cpu_dwe1,
  output logic [15:0] cpu_ddin,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [1:0]  host_be,
  input  logic [15:0] host_addr,
  input  logic [15:0] host_wdata,
  output logic        host_busy,
  output logic        host_ack,
  output logic [15:0] host_rdata,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_oe,
  output logic        mem_we0,
  output logic        mem_we1,
  input  logic [15:0] mem_rdata,
  output logic [7:0]  starve_cnt,
  output logic        starve_flag
);

  typedef enum logic [1:0] {IDLE, PEND, DONE} state_t;

  state_t      state_q, state_d;
  logic [15:0] buf_addr_q, buf_addr_d;
  logic [15:0] buf_wdata_q, buf_wdata_d;
  logic        buf_we_q, buf_we_d;
  logic [1:0]  buf_be_q, buf_be_d;
  logic [15:0] rdata_q, rdata_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        flag_q, flag_d;

  logic cpu_act;
  logic host_drive;

  assign cpu_act = cpu_doe | cpu_dwe0 | cpu_dwe1;
  // rst gates the host path so a pending op never reaches memory in the reset cycle
  assign host_drive = (state_q == PEND) & ~cpu_act & ~rst;

  always_comb begin
    if (host_drive) begin
      mem_addr  = buf_addr_q;
      mem_wdata = buf_wdata_q;
      mem_oe    = ~buf_we_q;
      mem_we0   = buf_we_q & buf_be_q[0];
      mem_we1   = buf_we_q & buf_be_q[1];
    end else begin
      mem_addr  = cpu_daddr;
      mem_wdata = cpu_ddout;
      mem_oe    = cpu_doe;
      mem_we0   = cpu_dwe0;
      mem_we1   = cpu_dwe1;
    end
  end

  assign cpu_ddin    = mem_rdata;
  assign host_busy   = (state_q != IDLE);
  assign host_ack    = (state_q == DONE);
  assign host_rdata  = rdata_q;
  assign starve_cnt  = cnt_q;
  assign starve_flag = flag_q;

  always_comb begin
    state_d     = state_q;
    buf_addr_d  = buf_addr_q;
    buf_wdata_d = buf_wdata_q;
    buf_we_d    = buf_we_q;
    buf_be_d    = buf_be_q;
    rdata_d     = rdata_q;
    cnt_d       = cnt_q;
    flag_d      = flag_q;
    case (state_q)
      IDLE: begin
        if (host_req) begin
          buf_addr_d  = host_addr;
          buf_wdata_d = host_wdata;
          buf_we_d    = host_we;
          buf_be_d    = host_be;
          cnt_d       = 8'd0;
          flag_d      = 1'b0;
          state_d     = PEND;
        end
      end
      PEND: begin
        if (!cpu_act) begin
          // access goes out this cycle; async read data is valid now
          if (!buf_we_q) rdata_d = mem_rdata;
          state_d = DONE;
        end else begin
          if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
          if (cnt_d >= STARVE_LIMIT) flag_d = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      buf_addr_q  <= 16'h0000;
      buf_wdata_q <= 16'h0000;
      buf_we_q    <= 1'b0;
      buf_be_q    <= 2'b00;
      rdata_q     <= 16'h0000;
      cnt_q       <= 8'd0;
      flag_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_addr_q  <= buf_addr_d;
      buf_wdata_q <= buf_wdata_d;
      buf_we_q    <= buf_we_d;
      buf_be_q    <= buf_be_d;
      rdata_q     <= rdata_d;
      cnt_q       <= cnt_d;
      flag_q      <= flag_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_daddr, cpu_ddout, cpu_ddin;
  logic        cpu_doe, cpu_dwe0, cpu_dwe1;
  logic        host_req, host_we;
  logic [1:0]  host_be;
  logic [15:0] host_addr, host_wdata, host_rdata;
  logic        host_busy, host_ack;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_oe, mem_we0, mem_we1;
  logic [7:0]  starve_cnt;
  logic        starve_flag;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {logic we; logic [15:0] rdata;} exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  dmem_arbiter #(.STARVE_LIMIT(8'd3)) dut (
    .clk(clk), .rst(rst),
    .cpu_daddr(cpu_daddr), .cpu_ddout(cpu_ddout), .cpu_doe(cpu_doe),
    .cpu_dwe0(cpu_dwe0), .cpu_dwe1(cpu_dwe1), .cpu_ddin(cpu_ddin),
    .host_req(host_req), .host_we(host_we), .host_be(host_be),
    .host_addr(host_addr), .host_wdata(host_wdata),
    .host_busy(host_busy), .host_ack(host_ack), .host_rdata(host_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_oe(mem_oe),
    .mem_we0(mem_we0), .mem_we1(mem_we1), .mem_rdata(mem_rdata),
    .starve_cnt(starve_cnt), .starve_flag(starve_flag)
  );

  // data memory model: async read, sync byte-lane write
  logic [15:0] mem [1024];
  assign mem_rdata = mem[mem_addr[9:0]];
  always @(posedge clk) begin
    if (mem_we0) mem[mem_addr[9:0]][15:8] <= mem_wdata[15:8];
    if (mem_we1) mem[mem_addr[9:0]][7:0]  <= mem_wdata[7:0];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  // one-cycle request pulse; returns just after the edge that accepted it
  task automatic do_req(input logic we, input logic [1:0] be, input logic [15:0] addr,
                        input logic [15:0] wdata, input logic [15:0] exp_rd);
    exp_t e;
    host_req = 1'b1; host_we = we; host_be = be; host_addr = addr; host_wdata = wdata;
    e.we = we; e.rdata = exp_rd;
    sb.push_back(e);
    tick;
    host_req = 1'b0;
  endtask

  task automatic wait_ack(input int max, output logic got);
    got = 1'b0;
    for (int c = 0; c <= max; c++) begin
      if (host_ack) begin got = 1'b1; break; end
      tick;
    end
  endtask

  task automatic cpu_write(input logic [15:0] addr, input logic [15:0] data);
    cpu_daddr = addr; cpu_ddout = data; cpu_dwe0 = 1'b1; cpu_dwe1 = 1'b1;
    tick;
    cpu_dwe0 = 1'b0; cpu_dwe1 = 1'b0; cpu_daddr = 16'h0000; cpu_ddout = 16'h0000;
  endtask

  task automatic test_reset;
    rst = 1'b1; host_req = 1'b1;
    tick; tick;
    host_req = 1'b0;
    n_cmp++;
    if ({host_busy, host_ack, starve_flag} !== 3'b000) begin
      n_bad++; $display("FAIL reset_status: got %b required 000", {host_busy, host_ack, starve_flag});
    end
    n_cmp++;
    if ({host_rdata, starve_cnt} !== 24'h0) begin
      n_bad++; $display("FAIL reset_regs: got %h required 000000", {host_rdata, starve_cnt});
    end
    rst = 1'b0;
    tick;
    n_cmp++;
    if (host_busy !== 1'b0) begin
      n_bad++; $display("FAIL reset_no_req: busy got %b required 0", host_busy);
    end
  endtask

  task automatic test_write_read;
    exp_t e;
    do_req(1'b1, 2'b11, 16'h0100, 16'hBEEF, 16'h0000);
    #1;
    n_cmp++;
    if ({mem_we0, mem_we1, mem_oe, mem_addr, mem_wdata} !== {3'b110, 16'h0100, 16'hBEEF}) begin
      n_bad++; $display("FAIL wr_issue: got %b %h %h required 110 0100 beef",
                        {mem_we0, mem_we1, mem_oe}, mem_addr, mem_wdata);
    end
    n_cmp++;
    if ({host_busy, host_ack} !== 2'b10) begin
      n_bad++; $display("FAIL wr_t1_status: got %b required 10", {host_busy, host_ack});
    end
    tick;
    n_cmp++;
    if ({host_busy, host_ack, mem_we0, mem_we1} !== 4'b1100) begin
      n_bad++; $display("FAIL wr_t2: got %b required 1100", {host_busy, host_ack, mem_we0, mem_we1});
    end
    if (host_ack && sb.size() > 0) e = sb.pop_front();
    tick;
    n_cmp++;
    if ({host_busy, host_ack} !== 2'b00 || mem[10'h100] !== 16'hBEEF) begin
      n_bad++; $display("FAIL wr_t3: got %b mem %h required 00 beef", {host_busy, host_ack}, mem[10'h100]);
    end
    do_req(1'b0, 2'b00, 16'h0100, 16'h0000, 16'hBEEF);
    #1;
    n_cmp++;
    if ({mem_oe, mem_we0, mem_we1, mem_addr} !== {3'b100, 16'h0100}) begin
      n_bad++; $display("FAIL rd_issue: got %b %h required 100 0100", {mem_oe, mem_we0, mem_we1}, mem_addr);
    end
    tick;
    n_cmp++;
    if (host_ack !== 1'b1) begin
      n_bad++; $display("FAIL rd_ack: got %b required 1", host_ack);
    end else if (sb.size() > 0) begin
      e = sb.pop_front();
      n_cmp++;
      if (host_rdata !== e.rdata) begin
        n_bad++; $display("FAIL rd_data: got %h required %h", host_rdata, e.rdata);
      end
    end
    tick;
  endtask

  task automatic test_cpu_priority;
    exp_t e;
    do_req(1'b0, 2'b11, 16'h0100, 16'h0000, 16'hBEEF);
    for (int i = 0; i < 5; i++) begin
      cpu_doe = 1'b1; cpu_daddr = 16'h0200 + 16'(i);
      #1;
      n_cmp++;
      if (mem_addr !== cpu_daddr || mem_oe !== 1'b1 || host_ack !== 1'b0) begin
        n_bad++; $display("FAIL prio_cpu_pass%0d: got addr %h ack %b required %h 0", i, mem_addr, host_ack, cpu_daddr);
      end
      tick;
    end
    cpu_doe = 1'b0; cpu_daddr = 16'h0000;
    #1;
    n_cmp++;
    if (mem_addr !== 16'h0100 || mem_oe !== 1'b1) begin
      n_bad++; $display("FAIL prio_host_issue: got %h %b required 0100 1", mem_addr, mem_oe);
    end
    tick;
    n_cmp++;
    if ({host_ack, starve_cnt, starve_flag} !== {1'b1, 8'd5, 1'b1}) begin
      n_bad++; $display("FAIL prio_ack: got ack %b cnt %0d flag %b required 1 5 1", host_ack, starve_cnt, starve_flag);
    end
    if (host_ack && sb.size() > 0) begin
      e = sb.pop_front();
      n_cmp++;
      if (host_rdata !== e.rdata) begin
        n_bad++; $display("FAIL prio_rdata: got %h required %h", host_rdata, e.rdata);
      end
    end
    tick;
  endtask

  task automatic test_byte_lanes;
    logic [1:0]  bes [3] = '{2'b10, 2'b01, 2'b00};
    logic [15:0] exps [3] = '{16'h12BB, 16'hAA34, 16'h1234};
    logic got;
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      cpu_write(16'h0010, 16'h1234);
      do_req(1'b1, bes[i], 16'h0010, 16'hAABB, 16'h0000);
      wait_ack(5, got);
      n_cmp++;
      if (got !== 1'b1) begin
        n_bad++; $display("FAIL be_ack%0d: got %b required 1", i, got);
      end
      if (got && sb.size() > 0) e = sb.pop_front();
      tick;
      n_cmp++;
      if (mem[10'h010] !== exps[i]) begin
        n_bad++; $display("FAIL be_mem%0d: got %h required %h", i, mem[10'h010], exps[i]);
      end
    end
  endtask

  task automatic test_starvation;
    logic got;
    exp_t e;
    do_req(1'b1, 2'b11, 16'h0030, 16'h7777, 16'h0000);
    for (int i = 1; i <= 4; i++) begin
      cpu_doe = 1'b1;
      tick;
      n_cmp++;
      if (starve_cnt !== 8'(i) || starve_flag !== (i >= 3)) begin
        n_bad++; $display("FAIL starve_step%0d: got cnt %0d flag %b required %0d %b", i, starve_cnt, starve_flag, i, i >= 3);
      end
    end
    cpu_doe = 1'b0;
    tick;
    n_cmp++;
    if ({host_ack, starve_flag} !== 2'b11) begin
      n_bad++; $display("FAIL starve_ack: got %b required 11", {host_ack, starve_flag});
    end
    if (host_ack && sb.size() > 0) e = sb.pop_front();
    tick;
    n_cmp++;
    if ({host_busy, starve_flag, starve_cnt} !== {2'b01, 8'd4}) begin
      n_bad++; $display("FAIL starve_hold: got busy %b flag %b cnt %0d required 0 1 4", host_busy, starve_flag, starve_cnt);
    end
    do_req(1'b0, 2'b00, 16'h0030, 16'h0000, 16'h7777);
    n_cmp++;
    if ({starve_flag, starve_cnt} !== 9'd0) begin
      n_bad++; $display("FAIL starve_clear: got flag %b cnt %0d required 0 0", starve_flag, starve_cnt);
    end
    wait_ack(5, got);
    n_cmp++;
    if (got !== 1'b1) begin
      n_bad++; $display("FAIL starve_rd_ack: got %b required 1", got);
    end else if (sb.size() > 0) begin
      e = sb.pop_front();
      n_cmp++;
      if (host_rdata !== e.rdata) begin
        n_bad++; $display("FAIL starve_rdata: got %h required %h", host_rdata, e.rdata);
      end
    end
    tick;
  endtask

  task automatic test_req_while_busy;
    int acks = 0;
    exp_t e;
    do_req(1'b0, 2'b00, 16'h0100, 16'h0000, 16'hBEEF);
    cpu_doe = 1'b1;
    host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0010;
    tick;
    cpu_doe = 1'b0;
    tick;
    for (int c = 0; c < 6; c++) begin
      if (host_ack) begin
        acks++;
        if (sb.size() > 0) e = sb.pop_front();
        n_cmp++;
        if (host_rdata !== e.rdata) begin
          n_bad++; $display("FAIL busy_rdata: got %h required %h", host_rdata, e.rdata);
        end
      end
      tick;
      host_req = 1'b0;
    end
    n_cmp++;
    if (acks != 1 || host_busy !== 1'b0) begin
      n_bad++; $display("FAIL busy_acks: got %0d acks busy %b required 1 0", acks, host_busy);
    end
  endtask

  task automatic test_reset_pend;
    logic got;
    exp_t e;
    cpu_write(16'h0020, 16'h0000);
    do_req(1'b1, 2'b11, 16'h0020, 16'h5555, 16'h0000);
    cpu_doe = 1'b1; cpu_daddr = 16'h0300;
    tick;
    rst = 1'b1; cpu_doe = 1'b0;
    #1;
    n_cmp++;
    if ({mem_we0, mem_we1, mem_oe, mem_addr} !== {3'b000, 16'h0300}) begin
      n_bad++; $display("FAIL rstp_mux: got %b %h required 000 0300", {mem_we0, mem_we1, mem_oe}, mem_addr);
    end
    tick;
    rst = 1'b0; cpu_daddr = 16'h0000;
    if (sb.size() > 0) e = sb.pop_front();
    n_cmp++;
    if ({host_busy, host_ack, host_rdata, starve_cnt} !== 26'd0) begin
      n_bad++; $display("FAIL rstp_regs: got busy %b ack %b rdata %h cnt %0d required 0 0 0000 0",
                        host_busy, host_ack, host_rdata, starve_cnt);
    end
    for (int c = 0; c < 4; c++) begin
      n_cmp++;
      if (host_ack !== 1'b0 || mem[10'h020] !== 16'h0000) begin
        n_bad++; $display("FAIL rstp_quiet%0d: got ack %b mem %h required 0 0000", c, host_ack, mem[10'h020]);
      end
      tick;
    end
    do_req(1'b1, 2'b11, 16'h0020, 16'h5555, 16'h0000);
    wait_ack(5, got);
    n_cmp++;
    if (got !== 1'b1) begin
      n_bad++; $display("FAIL rstp_after_ack: got %b required 1", got);
    end
    if (got && sb.size() > 0) e = sb.pop_front();
    tick;
    n_cmp++;
    if (mem[10'h020] !== 16'h5555) begin
      n_bad++; $display("FAIL rstp_after_mem: got %h required 5555", mem[10'h020]);
    end
  endtask

  initial begin
    rst = 1'b1;
    cpu_daddr = '0; cpu_ddout = '0; cpu_doe = 1'b0; cpu_dwe0 = 1'b0; cpu_dwe1 = 1'b0;
    host_req = 1'b0; host_we = 1'b0; host_be = '0; host_addr = '0; host_wdata = '0;
    test_reset;
    test_write_read;
    test_cpu_priority;
    test_byte_lanes;
    test_starvation;
    test_req_while_busy;
    test_reset_pend;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++; $display("FAIL scoreboard_drain: got %0d left required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the core's single data-memory port between the RISC16 pipeline and a host/debug port (loader, monitor, DMA). The CPU always has absolute priority and passes through combinationally, because its EX stage consumes read data in the same cycle and cannot stall. Host transactions are buffered and issued only in cycles where the CPU makes no data access. The block sits between the core's data port and the data-memory macro, which has asynchronous read and synchronous byte-lane write.

## Interface
Parameters:
- STARVE_LIMIT, default 8'd255: PEND-cycle count at which `starve_flag` asserts. Range 1..255.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- cpu_daddr  in  16  CPU data address
- cpu_ddout  in  16  CPU write data
- cpu_doe  in  1  CPU read enable
- cpu_dwe0  in  1  CPU write enable, byte [15:8] (even byte)
- cpu_dwe1  in  1  CPU write enable, byte [7:0] (odd byte)
- cpu_ddin  out  16  read data to CPU; equals `mem_rdata` at all times
- host_req  in  1  one-cycle request pulse; sampled only while `host_busy`=0
- host_we  in  1  1=write, 0=read
- host_be  in  2  write byte enables: [0]→byte [15:8], [1]→byte [7:0]
- host_addr  in  16  host address
- host_wdata  in  16  host write data
- host_busy  out  1  transaction in flight (state≠IDLE)
- host_ack  out  1  one-cycle completion pulse
- host_rdata  out  16  registered read data; holds its value until the next read completes
- mem_addr, mem_wdata  out  16  to memory
- mem_oe, mem_we0, mem_we1  out  1  to memory
- mem_rdata  in  16  asynchronous read data
- starve_cnt  out  8  PEND cycles spent waiting in the current transaction; saturates at 255
- starve_flag  out  1  sticky; set when starve_cnt ≥ STARVE_LIMIT

## Operation
- Define `cpu_act` = cpu_doe | cpu_dwe0 | cpu_dwe1.
- Memory mux (combinational):
  - If `cpu_act`=1, or state≠PEND, or rst=1: mem_* = cpu_* unchanged.
  - Otherwise (PEND and `cpu_act`=0) the buffered host operation is driven:
    - mem_addr = buf_addr
    - mem_oe = ~buf_we
    - mem_we0 = buf_we & buf_be[0]
    - mem_we1 = buf_we & buf_be[1]
    - mem_wdata = buf_wdata
- FSM states are IDLE, PEND and DONE.
  - IDLE: if host_req=1, latch addr/we/be/wdata into the buffer, clear starve_cnt and starve_flag, then go to PEND. If host_req=0, stay.
  - PEND:
    - If `cpu_act`=0, the access is issued this cycle. For a read, capture mem_rdata into host_rdata at the clock edge. Go to DONE.
    - Else increment starve_cnt (saturating at 255) and stay in PEND.
    - starve_flag sets on the edge where the new starve_cnt ≥ STARVE_LIMIT.
  - DONE: host_ack=1. Go to IDLE unconditionally. host_req is ignored.
- host_req is ignored in PEND and DONE. A pulse there is dropped with no error.
- Write with be=2'b00: issued with both write enables low (no memory change), still acked. host_be is ignored on reads.
- A host write never modifies host_rdata.
- starve_cnt and starve_flag hold their values after DONE until the next IDLE→PEND transition.

## Timing
- Reset values: state=IDLE, host_busy=0, host_ack=0, host_rdata=16'h0000, starve_cnt=0, starve_flag=0, buffer=0.
- Reset mid-transaction: the pending operation is discarded and no host access is issued in the reset cycle. The CPU path is unaffected.
- Best-case latency:
  - host_req at cycle T.
  - Access issued at T+1.
  - host_ack and valid host_rdata at T+2.
  - host_busy=1 during T+1 and T+2.
  - Earliest next accepted host_req is T+3.
- Each cycle the CPU is busy in PEND adds one cycle of latency. There is no upper bound, since the CPU never yields; starve_flag reports starvation.
- CPU path latency is zero (pure combinational). The arbiter never delays or blocks a CPU access.
- host_ack is registered (a state decode of DONE) and is high for exactly one cycle per accepted request.

## Test plan
- Idle CPU host write then read:
  - Write addr 16'h0100, data 16'hBEEF, be=2'b11: mem_we0=mem_we1=1 at T+1 only, ack at T+2.
  - Read of 16'h0100: host_rdata=16'hBEEF at T+2.
- CPU priority:
  - Host read issued while cpu_doe=1 for 5 consecutive cycles: mem_addr follows cpu_daddr throughout.
  - Host access occurs in cycle 6; ack in cycle 7; starve_cnt=5.
- Byte lanes:
  - Preload 16'h1234, then host write 16'hAABB with be=2'b10: memory reads 16'h12BB.
  - Preload 16'h1234, then be=2'b01: memory reads 16'hAA34.
  - be=2'b00: memory unchanged, ack still produced.
- Starvation:
  - STARVE_LIMIT=3, CPU busy 4 cycles: starve_flag rises on the edge where starve_cnt becomes 3 and stays set after ack.
  - Next host_req clears starve_flag and starve_cnt to 0.
- Request while busy:
  - Second host_req pulse during PEND or DONE: ignored; exactly one ack.
  - host_rdata reflects only the first request.
- Reset in PEND with CPU busy:
  - Assert rst for 1 cycle: no host memory access is ever issued.
  - host_busy=0, host_ack stays 0, host_rdata=16'h0000.
  - A new request afterwards completes normally.
